// File: rtl/spike_event_logger.sv
// Timestamps per-channel spike pulses into a first-word-fall-through FIFO read
// out on a valid/ready stream, and asks the time manager to freeze emulated time when nearly full.
module spike_event_logger #(
    parameter int N_CH         = 4,
    parameter int TIME_WIDTH   = 64,
    parameter int DT_WIDTH     = 32,
    parameter int DEPTH        = 16,
    parameter int STALL_MARGIN = 2,
    parameter int CNT_WIDTH    = 16,
    localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst_n,
    input  logic [TIME_WIDTH-1:0] emu_time,
    input  logic [N_CH-1:0]       spike_in,
    input  logic                  log_en,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [TIME_WIDTH-1:0] ev_time,
    output logic [N_CH-1:0]       ev_mask,
    output logic [DT_WIDTH-1:0]   dt_req_stall,
    input  logic [SEL_W-1:0]      cnt_sel,
    output logic [CNT_WIDTH-1:0]  cnt_out,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  overflow
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int REC_W = TIME_WIDTH + N_CH;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_TH_C = CW'(DEPTH - STALL_MARGIN);

    logic [REC_W-1:0]      mem [DEPTH];
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]         wr_ptr_next, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  ev_valid_reg;
    logic [TIME_WIDTH-1:0] ev_time_reg;
    logic [N_CH-1:0]       ev_mask_reg;
    logic [DT_WIDTH-1:0]   dt_req_reg;
    logic [CNT_WIDTH-1:0]  cnt_out_reg;
    logic [CNT_WIDTH-1:0]  drop_cnt_reg;
    logic                  overflow_reg;
    logic [CNT_WIDTH-1:0]  cnt_val [N_CH];

    logic             push_req, pop, full, push_ok, drop, bypass;
    logic [REC_W-1:0] rec_in;

    always_comb begin
        rec_in      = {emu_time, spike_in};
        push_req    = log_en && (|spike_in);
        pop         = ev_valid_reg && ev_ready;
        full        = (count_reg == DEPTH_C);
        push_ok     = push_req && (!full || pop);
        drop        = push_req && full && !pop;
        rd_ptr_next = pop     ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        wr_ptr_next = push_ok ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        count_next  = count_reg;
        if (push_ok && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push_ok)
            count_next = count_reg - CW'(1);
        // The new head is the record being written right now: forward it past the array.
        bypass = push_ok && (rd_ptr_next == wr_ptr_reg);
    end

    always_ff @(posedge emu_clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= rec_in;
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ev_valid_reg <= 1'b0;
            ev_time_reg  <= '0;
            ev_mask_reg  <= '0;
            dt_req_reg   <= '1;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            ev_valid_reg <= (count_next != '0);
            if (count_next != '0) begin
                if (bypass)
                    {ev_time_reg, ev_mask_reg} <= rec_in;
                else
                    {ev_time_reg, ev_mask_reg} <= mem[rd_ptr_next];
            end
            dt_req_reg <= (count_next >= STALL_TH_C) ? '0 : '1;
        end
    end

    // Per-channel counters see every enabled spike, even ones whose record is dropped.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge emu_clk or negedge emu_rst_n) begin
                if (!emu_rst_n)
                    cnt_reg <= '0;
                else if (log_en && spike_in[gi] && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            cnt_out_reg  <= '0;
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            cnt_out_reg <= (32'(cnt_sel) < N_CH) ? cnt_val[cnt_sel] : '0;
            if (drop && (drop_cnt_reg != '1))
                drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
            if (drop)
                overflow_reg <= 1'b1;
        end
    end

    assign ev_valid     = ev_valid_reg;
    assign ev_time      = ev_time_reg;
    assign ev_mask      = ev_mask_reg;
    assign dt_req_stall = dt_req_reg;
    assign cnt_out      = cnt_out_reg;
    assign drop_cnt     = drop_cnt_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger with a queue scoreboard for the head record.
module tb_spike_event_logger;

    localparam int DEPTH = 16;

    logic        emu_clk = 1'b0;
    logic        emu_rst_n;
    logic [63:0] emu_time;
    logic [3:0]  spike_in;
    logic        log_en;
    logic        ev_valid;
    logic        ev_ready;
    logic [63:0] ev_time;
    logic [3:0]  ev_mask;
    logic [31:0] dt_req_stall;
    logic [1:0]  cnt_sel;
    logic [15:0] cnt_out;
    logic [15:0] drop_cnt;
    logic        overflow;

    int n_vec  = 0;
    int n_miss = 0;
    logic [67:0] q [$];

    always #5 emu_clk = ~emu_clk;

    spike_event_logger dut (
        .emu_clk      (emu_clk),
        .emu_rst_n    (emu_rst_n),
        .emu_time     (emu_time),
        .spike_in     (spike_in),
        .log_en       (log_en),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_time      (ev_time),
        .ev_mask      (ev_mask),
        .dt_req_stall (dt_req_stall),
        .cnt_sel      (cnt_sel),
        .cnt_out      (cnt_out),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        chk({tag, ".valid"}, 64'(ev_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".time"}, ev_time, q[0][67:4]);
            chk({tag, ".mask"}, 64'(ev_mask), 64'(q[0][3:0]));
        end
    endtask

    // One clock: update the reference queue from the driven inputs, then check the head.
    task automatic tick(input string tag);
        bit pop, push;
        pop  = (q.size() != 0) && ev_ready;
        push = log_en && (spike_in != 4'b0);
        @(posedge emu_clk);
        if (pop)
            void'(q.pop_front());
        if (push && q.size() < DEPTH)
            q.push_back({emu_time, spike_in});
        #1;
        check_head(tag);
    endtask

    task automatic do_reset();
        emu_rst_n = 1'b0;
        q.delete();
        #3;
        @(posedge emu_clk);
        #1;
        emu_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_cnt [4];
        logic [63:0] t;
        exp_cnt = '{16'd1, 16'd1, 16'd0, 16'd1};
        emu_time = 64'd0; spike_in = 4'b0; log_en = 1'b1; ev_ready = 1'b0; cnt_sel = 2'd0;
        emu_rst_n = 1'b1;
        #2;
        do_reset();
        chk("rst.valid", 64'(ev_valid), 64'd0);
        chk("rst.time", ev_time, 64'd0);
        chk("rst.mask", 64'(ev_mask), 64'd0);
        chk("rst.dt", 64'(dt_req_stall), 64'hFFFF_FFFF);
        chk("rst.drop", 64'(drop_cnt), 64'd0);
        chk("rst.ovf", 64'(overflow), 64'd0);
        chk("rst.cnt", 64'(cnt_out), 64'd0);

        // Single spike, one-cycle latency, then popped.
        ev_ready = 1'b1; spike_in = 4'b0010; emu_time = 64'd100;
        tick("single");
        chk("single.valid", 64'(ev_valid), 64'd1);
        chk("single.time", ev_time, 64'd100);
        chk("single.mask", 64'(ev_mask), 64'h2);
        spike_in = 4'b0; cnt_sel = 2'd1;
        tick("single_pop");
        chk("single_pop.valid", 64'(ev_valid), 64'd0);
        chk("single.cnt1", 64'(cnt_out), 64'd1);

        // Several channels in one cycle form one record.
        do_reset();
        spike_in = 4'b1011; emu_time = 64'd200;
        tick("multi");
        chk("multi.mask", 64'(ev_mask), 64'hB);
        spike_in = 4'b0;
        tick("multi_pop");
        chk("multi_pop.valid", 64'(ev_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cnt_sel = 2'(k);
            tick("multi_cnt");
            chk($sformatf("multi.cnt%0d", k), 64'(cnt_out), 64'(exp_cnt[k]));
        end

        // Fill with no consumer: stall at 14 entries, 17th record dropped.
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spike_in = 4'((i % 15) + 1); emu_time = 64'(1000 + 3 * i);
            tick("fill");
            chk($sformatf("fill.dt%0d", i), 64'(dt_req_stall), (i + 1 >= 14) ? 64'd0 : 64'hFFFF_FFFF);
            chk("fill.head", ev_time, 64'd1000);
        end
        spike_in = 4'b1111; emu_time = 64'd2000;
        tick("drop");
        chk("drop.cnt", 64'(drop_cnt), 64'd1);
        chk("drop.ovf", 64'(overflow), 64'd1);
        spike_in = 4'b0; ev_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain.time%0d", j), ev_time, 64'(1000 + 3 * j));
            chk($sformatf("drain.mask%0d", j), 64'(ev_mask), 64'((j % 15) + 1));
            tick("drain");
        end
        chk("drain.valid", 64'(ev_valid), 64'd0);
        chk("drain.dt", 64'(dt_req_stall), 64'hFFFF_FFFF);
        chk("drain.ovf", 64'(overflow), 64'd1);

        // Full FIFO with push and pop together.
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spike_in = 4'b0001; emu_time = 64'(3000 + i);
            tick("full_fill");
        end
        ev_ready = 1'b1; spike_in = 4'b0101; emu_time = 64'd4000;
        tick("full_pp");
        chk("full_pp.drop", 64'(drop_cnt), 64'd0);
        chk("full_pp.head", ev_time, 64'd3001);
        chk("full_pp.dt", 64'(dt_req_stall), 64'd0);
        spike_in = 4'b0;
        for (int j = 0; j < 15; j++)
            tick("full_drain");
        chk("full_drain.last_time", ev_time, 64'd4000);
        chk("full_drain.last_mask", 64'(ev_mask), 64'h5);
        tick("full_drain_end");
        chk("full_drain.valid", 64'(ev_valid), 64'd0);

        // Random traffic across pointer wrap, honouring the stall request.
        do_reset();
        t = 64'd5000;
        for (int c = 0; c < 40; c++) begin
            ev_ready = ($urandom_range(0, 1) == 1);
            if (dt_req_stall != 32'd0) begin
                spike_in = 4'($urandom_range(0, 15));
                t = t + 64'd1;
            end else begin
                spike_in = 4'b0;
            end
            emu_time = t;
            tick("wrap");
        end
        spike_in = 4'b0; ev_ready = 1'b1;
        for (int j = 0; j < 20; j++)
            tick("wrap_drain");
        chk("wrap.drop", 64'(drop_cnt), 64'd0);
        chk("wrap.empty", 64'(ev_valid), 64'd0);

        // Asynchronous reset mid-burst.
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            spike_in = 4'b0100; emu_time = 64'(6000 + i);
            tick("burst");
        end
        spike_in = 4'b0;
        #2;
        emu_rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst.valid", 64'(ev_valid), 64'd0);
        chk("arst.dt", 64'(dt_req_stall), 64'hFFFF_FFFF);
        chk("arst.cnt", 64'(cnt_out), 64'd0);
        chk("arst.drop", 64'(drop_cnt), 64'd0);
        chk("arst.ovf", 64'(overflow), 64'd0);
        @(posedge emu_clk);
        #1;
        emu_rst_n = 1'b1;
        spike_in = 4'b1000; emu_time = 64'd7777;
        tick("post_rst");
        chk("post_rst.time", ev_time, 64'd7777);
        chk("post_rst.mask", 64'(ev_mask), 64'h8);
        spike_in = 4'b0; cnt_sel = 2'd2;
        tick("post_rst_idle");
        chk("post_rst.cnt2", 64'(cnt_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
